// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encoding,
// default boot PC and the sequential PC increment.
package if_pkg;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    CANCEL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_INCR;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// SRAM-like instruction read port: request/address out, accept and data-return
// strobes back. The fetch unit is the master, the instruction memory the slave.
interface if_fetch_unit_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/if_inst_buf.sv
// One-entry hold register for an instruction word that returned while the
// IF/ID register was stalled.
module if_inst_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // NOTE: this data register is reset on purpose -- its contents reach if_inst
  // combinationally, so it must never expose an unknown word.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (clear) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues reads on the
// instruction port and presents {if_pc, if_inst, if_addr_error} to IF/ID.
// Optional feature macro: IF_ADDR_ERR_EN (misaligned-PC detection and error path).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_stall,
  input  logic                   br_valid,
  input  logic [31:0]            br_target,
  input  logic                   exc_valid,
  input  logic [31:0]            exc_target,
  if_fetch_unit_if.master        bus,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_inst,
  output logic                   if_addr_error,
  output logic                   if_stall_req
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  buf_q;
  logic         addr_err;
  logic         fire;
  logic         buf_load;
  logic         buf_clear;
  logic         req_c;
  logic         valid_raw;
  logic         err_raw;
  logic [31:0]  word_raw;

`ifdef IF_ADDR_ERR_EN
  assign addr_err      = (pc[1:0] != 2'b00);
  assign bus.inst_addr = pc;
`else
  assign addr_err      = 1'b0;
  assign bus.inst_addr = {pc[31:2], 2'b00};
`endif

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      REQ: begin
        if (exc_valid) begin
          // A request accepted in the redirect cycle still returns data that must be dropped.
          state_nxt = (req_c && bus.inst_addr_ok) ? CANCEL : REQ;
        end else if (!addr_err && bus.inst_addr_ok) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (exc_valid) begin
          state_nxt = bus.inst_data_ok ? REQ : CANCEL;
        end else if (bus.inst_data_ok) begin
          state_nxt = id_stall ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (exc_valid || fire) state_nxt = REQ;
      end
      CANCEL: begin
        if (bus.inst_data_ok) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    req_c     = 1'b0;
    valid_raw = 1'b0;
    err_raw   = 1'b0;
    word_raw  = '0;
    if (!reset) begin
      unique case (state)
        REQ: begin
          if (addr_err) begin
            valid_raw = 1'b1;
            err_raw   = 1'b1;
          end else begin
            req_c = 1'b1;
          end
        end
        WAIT: begin
          if (bus.inst_data_ok) begin
            valid_raw = 1'b1;
            word_raw  = bus.inst_rdata;
          end
        end
        HOLD: begin
          valid_raw = 1'b1;
          word_raw  = buf_q;
        end
        default: ;
      endcase
    end
    if_valid      = valid_raw && !exc_valid;
    if_inst       = if_valid ? word_raw : 32'd0;
    if_addr_error = if_valid && err_raw;
  end

  assign bus.inst_req = req_c;
  assign if_pc        = pc;
  assign if_stall_req = !if_valid;
  assign fire         = if_valid && !id_stall && !exc_valid;

  // ---------------- fetch PC ----------------
  // The fired instruction is the delay slot, so a pending branch lands after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (exc_valid) begin
      pc <= exc_target;
    end else if (fire) begin
      pc <= br_valid ? br_target : next_seq_pc(pc);
    end
  end

  // ---------------- hold buffer ----------------
  assign buf_load  = (state == WAIT) && bus.inst_data_ok && id_stall && !exc_valid;
  assign buf_clear = fire || exc_valid;

  if_inst_buf u_inst_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (bus.inst_rdata),
    .dout  (buf_q)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit: the instruction port is
// driven step by step from one initial block with hand-computed expectations.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_addr_error;
  logic        if_stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .id_stall      (id_stall),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .exc_valid     (exc_valid),
    .exc_target    (exc_target),
    .bus           (bus),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_addr_error (if_addr_error),
    .if_stall_req  (if_stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs, then let combinational outputs settle.
  task automatic drive(input logic aok, input logic dok, input logic [31:0] rdata,
                       input logic stall, input logic brv, input logic [31:0] brt,
                       input logic excv, input logic [31:0] exct);
    bus.inst_addr_ok = aok;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = rdata;
    id_stall         = stall;
    br_valid         = brv;
    br_target        = brt;
    exc_valid        = excv;
    exc_target       = exct;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_req",   32'(bus.inst_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_inst",  if_inst, 32'd0);
    chk("rst_err",   32'(if_addr_error), 32'd0);
    chk("rst_pc",    if_pc, 32'hBFC0_0000);
    chk("rst_stall", 32'(if_stall_req), 32'd1);
    tick();
    reset = 1'b0;

    // Sequential fetch, zero-wait memory.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("a1_req",  32'(bus.inst_req), 32'd1);
    chk("a1_addr", bus.inst_addr, 32'hBFC0_0000);
    chk("a1_valid", 32'(if_valid), 32'd0);
    tick();
    drive(0, 1, 32'h1111_1111, 0, 0, 0, 0, 0);
    chk("a2_valid", 32'(if_valid), 32'd1);
    chk("a2_inst",  if_inst, 32'h1111_1111);
    chk("a2_pc",    if_pc, 32'hBFC0_0000);
    chk("a2_req",   32'(bus.inst_req), 32'd0);
    chk("a2_stall", 32'(if_stall_req), 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("a3_req",  32'(bus.inst_req), 32'd1);
    chk("a3_addr", bus.inst_addr, 32'hBFC0_0004);
    tick();

    // Data returns under a 3-cycle stall; word held in the buffer.
    drive(0, 1, 32'h2402_0001, 1, 0, 0, 0, 0);
    chk("a4_valid", 32'(if_valid), 32'd1);
    chk("a4_inst",  if_inst, 32'h2402_0001);
    tick();
    drive(0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    chk("h1_valid", 32'(if_valid), 32'd1);
    chk("h1_inst",  if_inst, 32'h2402_0001);
    chk("h1_pc",    if_pc, 32'hBFC0_0004);
    chk("h1_req",   32'(bus.inst_req), 32'd0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    chk("h2_inst", if_inst, 32'h2402_0001);
    chk("h2_pc",   if_pc, 32'hBFC0_0004);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("h3_valid", 32'(if_valid), 32'd1);
    chk("h3_inst",  if_inst, 32'h2402_0001);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("b1_addr", bus.inst_addr, 32'hBFC0_0008);
    chk("b1_req",  32'(bus.inst_req), 32'd1);
    tick();

    // Taken branch while the delay slot at 0xBFC00008 fires.
    drive(0, 1, 32'h0000_0021, 0, 1, 32'hBFC0_0100, 0, 0);
    chk("b2_valid", 32'(if_valid), 32'd1);
    chk("b2_pc",    if_pc, 32'hBFC0_0008);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("b3_addr", bus.inst_addr, 32'hBFC0_0100);
    tick();

    // Exception one cycle after acceptance: returning data must be dropped.
    drive(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
    chk("b4_valid", 32'(if_valid), 32'd0);
    chk("b4_inst",  if_inst, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("c1_req",   32'(bus.inst_req), 32'd0);
    chk("c1_valid", 32'(if_valid), 32'd0);
    tick();
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    chk("c2_valid", 32'(if_valid), 32'd0);
    chk("c2_inst",  if_inst, 32'd0);
    chk("c2_req",   32'(bus.inst_req), 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("c3_req",  32'(bus.inst_req), 32'd1);
    chk("c3_addr", bus.inst_addr, 32'hBFC0_0380);
    tick();
    drive(0, 1, 32'h1234_5678, 0, 1, 32'hBFC0_0102, 0, 0);
    chk("c4_pc",   if_pc, 32'hBFC0_0380);
    chk("c4_inst", if_inst, 32'h1234_5678);
    tick();

    // Misaligned branch target.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d1_pc", if_pc, 32'hBFC0_0102);
`ifdef IF_ADDR_ERR_EN
    chk("d1_req",   32'(bus.inst_req), 32'd0);
    chk("d1_valid", 32'(if_valid), 32'd1);
    chk("d1_err",   32'(if_addr_error), 32'd1);
    chk("d1_inst",  if_inst, 32'd0);
`else
    chk("d1_req",   32'(bus.inst_req), 32'd1);
    chk("d1_addr",  bus.inst_addr, 32'hBFC0_0100);
    chk("d1_err",   32'(if_addr_error), 32'd0);
    chk("d1_valid", 32'(if_valid), 32'd0);
`endif
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0000);
    chk("d2_valid", 32'(if_valid), 32'd0);
    chk("d2_err",   32'(if_addr_error), 32'd0);
    tick();

    // Reset asserted while a fetch is outstanding.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("e1_addr", bus.inst_addr, 32'hBFC0_0000);
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("e2_req",   32'(bus.inst_req), 32'd0);
    chk("e2_valid", 32'(if_valid), 32'd0);
    tick();
    reset = 1'b0;

    // Back in REQ; exception coincident with acceptance -> CANCEL, PC wraps later.
    drive(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("e3_req",   32'(bus.inst_req), 32'd1);
    chk("e3_addr",  bus.inst_addr, 32'hBFC0_0000);
    chk("e3_valid", 32'(if_valid), 32'd0);
    chk("e3_inst",  if_inst, 32'd0);
    tick();
    drive(0, 1, 32'h5555_AAAA, 0, 0, 0, 0, 0);
    chk("f1_req",   32'(bus.inst_req), 32'd0);
    chk("f1_valid", 32'(if_valid), 32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    chk("f2_addr", bus.inst_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 1, 32'hAAAA_5555, 0, 0, 0, 0, 0);
    chk("f3_pc",   if_pc, 32'hFFFF_FFFC);
    chk("f3_inst", if_inst, 32'hAAAA_5555);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("f4_req",  32'(bus.inst_req), 32'd1);
    chk("f4_addr", bus.inst_addr, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage front end: owns the architectural fetch PC, issues instruction reads over the SRAM-like instruction port, and presents `{if_pc, if_inst, if_addr_error}` with a valid flag to the IF/ID pipeline register. It honours the downstream stall, applies taken-branch targets after the delay slot, and applies exception/ERET redirects immediately, discarding any in-flight fetch.

## Interface
- `RESET_PC`, 32'hBFC0_0000: PC after reset.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `id_stall` in 1: IF/ID register holding; the current IF instruction must not advance.
- `br_valid` in 1: ID holds a taken branch; stays stable while `id_stall`=1.
- `br_target` in 32: branch target.
- `exc_valid` in 1: one-cycle exception/ERET redirect pulse; highest priority.
- `exc_target` in 32: redirect PC.
- `inst_req` out 1: read request.
- `inst_addr` out 32: request address = PC.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: read data returned this cycle.
- `inst_rdata` in 32: returned instruction.
- `if_valid` out 1: IF outputs are valid.
- `if_pc` out 32: PC of presented instruction.
- `if_inst` out 32: instruction word; 0 when `if_valid`=0 or on address error.
- `if_addr_error` out 1: fetch PC misaligned.
- `if_stall_req` out 1: = !`if_valid`; the pipeline controller stalls/bubbles on it.

## Operation
- fire = `if_valid` & !`id_stall` & !`exc_valid`. On fire: PC <= `br_valid` ? `br_target` : PC+4 (the fired instruction is the delay slot).
- `exc_valid` in any state: PC <= `exc_target`, `if_valid` forced 0 that cycle, no fire.
- States:
  - REQ: `inst_req`=1 with `inst_addr`=PC. On `inst_addr_ok` -> WAIT. Misaligned PC (PC[1:0]!=0): no request, `if_valid`=1, `if_addr_error`=1, `if_inst`=0; on fire -> REQ with new PC. `exc_valid` without `inst_addr_ok` -> stay REQ with new PC. `exc_valid` with `inst_addr_ok` -> CANCEL.
  - WAIT: on `inst_data_ok`, `if_valid`=1 and `if_inst`=`inst_rdata` combinationally. Fire -> REQ. Stall -> word captured into hold buffer, -> HOLD. `exc_valid`: before `inst_data_ok` -> CANCEL; with `inst_data_ok` -> REQ, data dropped.
  - HOLD: `if_valid`=1 from the buffer. Fire -> REQ. `exc_valid` -> REQ.
  - CANCEL: `inst_req`=0. `inst_data_ok` is dropped -> REQ. A further `exc_valid` updates PC and stays CANCEL.
- At most one request outstanding. The port never returns `inst_data_ok` in the same cycle as its `inst_addr_ok`.
- PC+4 wraps modulo 2^32.

## Timing
- Reset values: PC=`RESET_PC`, state=REQ, hold buffer=0, `if_valid`=0, `if_inst`=0, `if_addr_error`=0, `inst_req`=0 while `reset`=1. First request is issued the cycle after `reset` falls.
- Best case: `inst_addr_ok` in cycle N, `inst_data_ok` in N+1. Instruction is valid in N+1, fires in N+1, and the next request is issued in N+2. Throughput is one instruction per 2 cycles.
- `if_*` outputs stay stable while `if_valid`=1 and `id_stall`=1.
- Reset mid-fetch returns to REQ. The instruction port is reset by the same `reset`, so no stale `inst_data_ok` follows.

## Configuration
- `IF_ADDR_ERR_EN` defined: the misaligned-PC check and error path exist as described.
- `IF_ADDR_ERR_EN` undefined: `if_addr_error` is tied to 0, `inst_addr`={PC[31:2],2'b00}, and every PC issues a request.

## Structure
- Shared package `if_pkg`: state enum {REQ, WAIT, HOLD, CANCEL}, default `RESET_PC`, the constant 32'd4 increment.
- Sub-module `if_inst_buf`: one-entry hold register (load on stall-with-data, clear on fire/exception/reset).

## Test plan
- Reset release, memory grants `inst_addr_ok` immediately and `inst_data_ok` one cycle later, no stall -> requests at 0xBFC00000, 0xBFC00004, 0xBFC00008 on alternating cycles; `if_valid` pulses on each data return.
- `id_stall`=1 for 3 cycles as `inst_data_ok` returns 0x24020001 -> HOLD keeps `if_inst`=0x24020001 and `if_pc` stable; fire on release; next request is PC+4.
- `br_valid`=1, `br_target`=0xBFC00100 while the delay slot at 0xBFC00008 fires -> next `inst_addr`=0xBFC00100.
- `exc_valid`, `exc_target`=0xBFC00380 one cycle after `inst_addr_ok` -> no `if_valid`; the returning `inst_data_ok` is dropped; next request is 0xBFC00380.
- With `IF_ADDR_ERR_EN`, `br_target`=0xBFC00102 -> no `inst_req`; `if_valid`=1, `if_addr_error`=1, `if_inst`=0, `if_pc`=0xBFC00102. Without the macro -> request at 0xBFC00100 and `if_addr_error`=0.
- `reset` asserted while in WAIT -> next cycle: state REQ, PC=0xBFC00000, all outputs at reset values.
